unsigned_divider_16by8_seq: RTL
===============================

# unsigned_divider_16by8_seq

Sequential unsigned restoring divider, the inverse operator of the 8x8 unsigned multiplier family: takes a 16-bit dividend `z` and an 8-bit divisor `y` and returns a 16-bit quotient and an 8-bit remainder such that z = q*y + r. It sits beside the multiplier bank to recover operands from products in the error-characterisation datapath, one bit per clock. It uses valid/ready handshakes on both ends.

## Interface
- N, default 8, divisor width; the dividend and quotient are 2N bits wide.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  the operand pair is valid.
- in_ready  output  1  the block accepts operands; high only in IDLE.
- z  input  2N  dividend, unsigned.
- y  input  N  divisor, unsigned.
- out_valid  output  1  the result is valid and held until it is taken.
- out_ready  input  1  the consumer takes the result.
- q  output  2N  quotient.
- r  output  N  remainder.
- div_by_zero  output  1  qualifies the result: y was 0 at accept.

## Operation
- **States:**
  - IDLE: in_ready=1.
  - BUSY: one restoring step per cycle.
  - DONE: out_valid=1.
- **Accept:** happens on a rising edge with in_valid && in_ready.
  - The block latches the dividend into the quotient/shift register and the divisor into a divisor register.
  - The partial remainder (N+1 bits) clears to 0 and the step counter clears to 0.
  - If y==0, the state goes to DONE; otherwise it goes to BUSY.
- **BUSY step:**
  - Form t = {rem[N-1:0], qreg[2N-1]}, which is N+1 bits.
  - Shift qreg left by 1.
  - If t >= {1'b0, div}: rem = t - div and qreg[0] = 1. Otherwise: rem = t and qreg[0] = 0.
  - The counter increments. After the step with counter == 2N-1, the state goes to DONE.
- **Width rules:** the compare and subtract are N+1 bits wide. The remainder after the final step always fits in N bits, so r = rem[N-1:0]. There is no quotient overflow, because the quotient is 2N bits.
- **Divide by zero:** q = {2N{1'b1}}, r = z[N-1:0] (latched), div_by_zero = 1. For a normal result, div_by_zero = 0.
- **DONE:**
  - q, r and div_by_zero are stable while out_valid=1 && !out_ready.
  - On out_ready, the state goes to IDLE.
  - No new operand is accepted in the same cycle, because in_ready=0 in DONE.
- **Reset:** rst=1 at any edge forces IDLE and clears q, r, rem, the counter and div_by_zero to 0.
  - An operation in flight is discarded and no out_valid is produced for it.
  - rst has priority over accept and handshakes in the same cycle.
- **Reset values of the outputs:** in_ready=1, out_valid=0, q=0, r=0, div_by_zero=0.
- **Input changes:** z and y changing after accept have no effect.

## Timing
- Accept on edge k. out_valid is high after edge k+2N (k+16 for N=8). This gives 2N cycles of latency and 2N+1 cycles per operation when out_ready is held high.
- Divide by zero: out_valid is high after edge k+1.
- in_ready falls after the accept edge and rises again after the edge where out_valid && out_ready.
- Back-to-back throughput: one result every 2N+2 cycles, counting the IDLE cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- **Package `unsigned_div_pkg`:**
  - The state enum {IDLE, BUSY, DONE}.
  - Localparam CNT_W = $clog2(2N).
  - The divide-by-zero quotient constant.
- **Sub-module `unsigned_div_step`:** combinational, parameterised by N.
  - Inputs: rem_in[N-1:0], msb_in, div[N-1:0].
  - Outputs: rem_out[N-1:0], qbit.
  - The top level holds the FSM, the counter, the registers and the handshake logic.

## Test plan
- z=16'd50000, y=8'd7, out_ready=1 → after 16 cycles: q=7142, r=6, div_by_zero=0; in_ready returns high one cycle later.
- z=16'hFFFF, y=8'd1 → q=16'hFFFF, r=0. Also z=16'd0, y=8'd255 → q=0, r=0.
- z=16'h1234, y=0 → out_valid one cycle after accept with q=16'hFFFF, r=8'h34, div_by_zero=1.
- Backpressure: out_ready=0 for 10 cycles after completion of z=1000, y=13 → q=76 and r=12 held constant, in_ready=0 throughout, and in_valid pulses are ignored.
- rst asserted at step 8 of z=40000, y=3 → the next cycle shows IDLE with outputs zero and no out_valid. A following z=40000, y=3 gives q=13333, r=1.
- Random sweep of 10k pairs plus exhaustive y over 1..255 → every result satisfies q*y + r == z and r < y. Round-trip check: exact products z = a*b divided by b give q=a, r=0.

Source files
------------

// File: rtl/unsigned_div_pkg.sv
// Shared types and constants for the sequential 2N/N unsigned restoring divider.
package unsigned_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DEF_N = 8;
  localparam int CNT_W = $clog2(2 * DEF_N);

  // Quotient reported when the divisor is zero (all ones at the default width)
  localparam logic [2*DEF_N-1:0] DBZ_QUOT = '1;

  function automatic int cnt_w(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/unsigned_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module unsigned_div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem_in,
  input  logic         msb_in,
  input  logic [N-1:0] div,
  output logic [N-1:0] rem_out,
  output logic         qbit
);

  logic [N:0] t;
  logic       ge;

  always_comb begin
    t       = {rem_in, msb_in};
    ge      = (t >= {1'b0, div});
    qbit    = ge;
    // After a failed trial t < div, so it always fits back into N bits
    rem_out = ge ? N'(t - {1'b0, div}) : t[N-1:0];
  end

endmodule

// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential unsigned divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock,
// valid/ready on both sides, results held in DONE until taken.
module unsigned_divider_16by8_seq
  import unsigned_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] z,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           div_by_zero
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0]  LAST_STEP = CW'(2 * N - 1);
  localparam logic [2*N-1:0] ALL_ONES  = '1;

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] qreg_q, qreg_d;
  logic [N-1:0]   div_q, div_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N-1:0]   step_rem;
  logic           step_qbit;

  unsigned_div_step #(.N(N)) u_step (
    .rem_in  (rem_q),
    .msb_in  (qreg_q[2*N-1]),
    .div     (div_q),
    .rem_out (step_rem),
    .qbit    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qreg_d  = qreg_q;
    div_d   = div_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          qreg_d = z;
          div_d  = y;
          rem_d  = '0;
          cnt_d  = '0;
          dbz_d  = 1'b0;
          state_d = BUSY;
          if (y == '0) begin
            // Zero divisor skips the iteration and reports a saturated quotient
            qreg_d  = ALL_ONES;
            rem_d   = z[N-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        qreg_d = {qreg_q[2*N-2:0], step_qbit};
        rem_d  = step_rem;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qreg_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qreg_q  <= qreg_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign q           = qreg_q;
  assign r           = rem_q;
  assign div_by_zero = dbz_q;

endmodule
